// File: rtl/x_sweep_ctrl.sv
// x_sweep_ctrl: sweeps enabled delay-line channels, launching, capturing and serializing each in turn
module x_sweep_ctrl #(
    parameter int p_length   = 32,
    parameter int p_channels = 4,
    parameter int p_settle   = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_trig,
    input  logic [p_channels-1:0]            i_ch_mask,
    input  logic [p_channels*p_length-1:0]   i_data,
    output logic                             o_launch,
    output logic [$clog2(p_channels)-1:0]    o_sel,
    output logic [p_length-1:0]              o_snap,
    output logic                             o_tx_valid,
    input  logic                             i_tx_done,
    output logic                             o_busy,
    output logic                             o_done
);
    localparam int c_sw = $clog2(p_channels);
    localparam int c_cw = $clog2(p_settle + 1);
    localparam logic [c_cw-1:0] c_cnt_last = c_cw'(p_settle - 1);

    typedef enum logic [2:0] {
        s_idle, s_launch, s_settle, s_capture, s_send, s_next
    } state_t;

    state_t                state_q, state_d;
    logic [p_channels-1:0] mask_q, rem;
    logic [c_sw-1:0]       sel_q;
    logic [p_length-1:0]   snap_q;
    logic [c_cw-1:0]       cnt_q;
    logic                  zdone_q;

    function automatic logic [c_sw-1:0] lowest(input logic [p_channels-1:0] m);
        lowest = '0;
        for (int i = p_channels - 1; i >= 0; i--)
            if (m[i]) lowest = c_sw'(i);
    endfunction

    // mask with the channel just served removed
    always_comb begin
        rem        = mask_q;
        rem[sel_q] = 1'b0;
    end

    // state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= s_idle;
        else       state_q <= state_d;
    end

    // next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            s_idle:    state_d = (i_trig && |i_ch_mask) ? s_launch : s_idle;
            s_launch:  state_d = s_settle;
            s_settle:  state_d = (cnt_q == c_cnt_last) ? s_capture : s_settle;
            s_capture: state_d = s_send;
            s_send:    state_d = i_tx_done ? s_next : s_send;
            s_next:    state_d = |rem ? s_launch : s_idle;
            default:   state_d = s_idle;
        endcase
    end

    // mask, channel select, settle counter and snapshot registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mask_q  <= '0;
            sel_q   <= '0;
            snap_q  <= '0;
            cnt_q   <= '0;
            zdone_q <= 1'b0;
        end else begin
            zdone_q <= state_q == s_idle && i_trig && ~|i_ch_mask;
            if (state_q == s_idle && i_trig) begin
                mask_q <= i_ch_mask;
                sel_q  <= lowest(i_ch_mask);
            end
            if (state_q == s_launch)
                cnt_q <= '0;
            else if (state_q == s_settle && cnt_q != c_cnt_last)
                cnt_q <= cnt_q + 1'b1;
            if (state_q == s_capture)
                snap_q <= i_data[sel_q*p_length +: p_length];
            if (state_q == s_next) begin
                mask_q <= rem;
                if (|rem) sel_q <= lowest(rem);
            end
        end
    end

    assign o_launch   = state_q == s_launch;
    assign o_tx_valid = state_q == s_send;
    assign o_busy     = state_q != s_idle;
    assign o_done     = zdone_q || (state_q == s_next && ~|rem);
    assign o_sel      = sel_q;
    assign o_snap     = snap_q;
endmodule

// File: tb/tb_x_sweep_ctrl.sv
// tb_x_sweep_ctrl: directed checks of x_sweep_ctrl with 4 channels, 32-bit taps, settle 4
module tb_x_sweep_ctrl;
    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_trig = 1'b0;
    logic [3:0]   i_ch_mask = '0;
    logic [127:0] i_data = '0;
    logic         i_tx_done = 1'b0;
    logic         o_launch, o_tx_valid, o_busy, o_done;
    logic [1:0]   o_sel;
    logic [31:0]  o_snap;

    int n_cmp = 0;
    int n_err = 0;
    int n_launch = 0;
    int n_done = 0;
    logic [3:0] seen = '0;
    int l0, d0;

    x_sweep_ctrl #(.p_length(32), .p_channels(4), .p_settle(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_trig(i_trig), .i_ch_mask(i_ch_mask),
        .i_data(i_data), .o_launch(o_launch), .o_sel(o_sel), .o_snap(o_snap),
        .o_tx_valid(o_tx_valid), .i_tx_done(i_tx_done), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    // tally launches, selected channels and done pulses
    always @(negedge i_clk) begin
        if (o_launch) begin
            n_launch++;
            seen[o_sel] = 1'b1;
        end
        if (o_done) n_done++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(negedge i_clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 64'(o_busy), 64'd0);
        chk({tag, "_launch"}, 64'(o_launch), 64'd0);
        chk({tag, "_txv"}, 64'(o_tx_valid), 64'd0);
        chk({tag, "_done"}, 64'(o_done), 64'd0);
    endtask

    // entered at the LAUNCH cycle, returns in the NEXT cycle
    task automatic serve(input int ch, input logic [31:0] exp, input int hold, input bit noise);
        chk("launch", 64'(o_launch), 64'd1);
        chk("launch_sel", 64'(o_sel), 64'(ch));
        chk("launch_busy", 64'(o_busy), 64'd1);
        for (int i = 0; i < 5; i++) begin
            if (noise && i == 1) i_trig = 1'b1;
            if (noise && i == 2) i_tx_done = 1'b1;
            step;
            i_trig = 1'b0;
            i_tx_done = 1'b0;
            chk("settle_launch", 64'(o_launch), 64'd0);
            chk("settle_txv", 64'(o_tx_valid), 64'd0);
        end
        step;
        chk("send_txv", 64'(o_tx_valid), 64'd1);
        chk("send_snap", 64'(o_snap), 64'(exp));
        chk("send_sel", 64'(o_sel), 64'(ch));
        i_data = ~i_data;
        for (int j = 0; j < hold; j++) begin
            if (noise && j == 0) i_trig = 1'b1;
            step;
            i_trig = 1'b0;
            chk("hold_txv", 64'(o_tx_valid), 64'd1);
            chk("hold_snap", 64'(o_snap), 64'(exp));
            chk("hold_sel", 64'(o_sel), 64'(ch));
        end
        i_data = ~i_data;
        i_tx_done = 1'b1;
        step;
        i_tx_done = 1'b0;
        chk("next_txv", 64'(o_tx_valid), 64'd0);
        chk("next_busy", 64'(o_busy), 64'd1);
    endtask

    initial begin
        i_data = {32'hCAFE0003, 32'h0000FFFF, 32'hBEEF0002, 32'hA5A5A5A5};
        step;
        step;
        chk_idle("rst");
        chk("rst_sel", 64'(o_sel), 64'd0);
        chk("rst_snap", 64'(o_snap), 64'd0);
        i_rst = 1'b0;
        step;
        chk_idle("idle");

        // scenario 1: single channel 0
        i_data = {32'hCAFE0003, 32'h0000FFFF, 32'hBEEF0002, 32'h11223344};
        l0 = n_launch;
        d0 = n_done;
        i_ch_mask = 4'b0001;
        i_trig = 1'b1;
        step;
        i_trig = 1'b0;
        serve(0, 32'h11223344, 22, 1'b0);
        chk("s1_done", 64'(o_done), 64'd1);
        step;
        chk_idle("s1_end");
        chk("s1_launches", 64'(n_launch - l0), 64'd1);
        chk("s1_dones", 64'(n_done - d0), 64'd1);

        // scenario 2: channels 1 and 3, mask changed mid-sweep
        i_data = {32'h0000FFFF, 32'h77777777, 32'hA5A5A5A5, 32'h99999999};
        l0 = n_launch;
        seen = '0;
        i_ch_mask = 4'b1010;
        i_trig = 1'b1;
        step;
        i_trig = 1'b0;
        i_ch_mask = 4'b1111;
        serve(1, 32'hA5A5A5A5, 3, 1'b0);
        chk("s2_mid_done", 64'(o_done), 64'd0);
        step;
        serve(3, 32'h0000FFFF, 3, 1'b0);
        chk("s2_done", 64'(o_done), 64'd1);
        step;
        chk_idle("s2_end");
        chk("s2_launches", 64'(n_launch - l0), 64'd2);
        chk("s2_seen", 64'(seen), 64'b1010);

        // scenario 3: empty mask
        l0 = n_launch;
        i_ch_mask = 4'b0000;
        i_trig = 1'b1;
        step;
        i_trig = 1'b0;
        chk("s3_done", 64'(o_done), 64'd1);
        chk("s3_busy", 64'(o_busy), 64'd0);
        chk("s3_launch", 64'(o_launch), 64'd0);
        step;
        chk_idle("s3_end");
        chk("s3_launches", 64'(n_launch - l0), 64'd0);

        // scenario 4: stray triggers and tx_done, trigger on the done cycle
        i_data = {32'hCAFE0003, 32'h0000FFFF, 32'hBEEF0002, 32'h11223344};
        l0 = n_launch;
        d0 = n_done;
        i_ch_mask = 4'b0001;
        i_trig = 1'b1;
        step;
        i_trig = 1'b0;
        serve(0, 32'h11223344, 22, 1'b1);
        chk("s4_done", 64'(o_done), 64'd1);
        i_trig = 1'b1;
        step;
        i_trig = 1'b0;
        chk_idle("s4_end");
        step;
        chk_idle("s4_end2");
        chk("s4_launches", 64'(n_launch - l0), 64'd1);
        chk("s4_dones", 64'(n_done - d0), 64'd1);

        // scenario 5: asynchronous reset during SEND, then restart
        i_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        d0 = n_done;
        i_ch_mask = 4'b1111;
        i_trig = 1'b1;
        step;
        i_trig = 1'b0;
        for (int i = 0; i < 6; i++) step;
        chk("s5_send", 64'(o_tx_valid), 64'd1);
        chk("s5_sel", 64'(o_sel), 64'd0);
        #2 i_rst = 1'b1;
        #1;
        chk_idle("s5_rst");
        chk("s5_rst_sel", 64'(o_sel), 64'd0);
        chk("s5_rst_snap", 64'(o_snap), 64'd0);
        step;
        i_rst = 1'b0;
        step;
        chk_idle("s5_post");
        chk("s5_no_done", 64'(n_done - d0), 64'd0);
        i_trig = 1'b1;
        step;
        i_trig = 1'b0;
        for (int c = 0; c < 4; c++) begin
            serve(c, 32'(32'h11111111 * (c + 1)), 2, 1'b0);
            chk("s5_done", 64'(o_done), 64'(c == 3));
            step;
        end
        chk_idle("s5_end");

        // scenario 6: top channel only, long serializer stall
        i_data = {32'hDEADBEEF, 32'h33333333, 32'h22222222, 32'h11111111};
        i_ch_mask = 4'b1000;
        i_trig = 1'b1;
        step;
        i_trig = 1'b0;
        serve(3, 32'hDEADBEEF, 1000, 1'b0);
        chk("s6_done", 64'(o_done), 64'd1);
        step;
        chk_idle("s6_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
